// File: rtl/residual_add.sv
// rtl/residual_add.sv - shortcut FIFO plus two-stage saturating residual adder
// Define RESADD_RELU_EN to clamp negative results to zero (ReLU) at the output.
module residual_add #(
    parameter int WIDTH_D = 27,
    parameter int WIDTH_O = 27,
    parameter int DEPTH   = 64
) (
    input  logic                      i_sclk,
    input  logic                      i_rst,
    input  logic                      i_s_valid,
    input  logic signed [WIDTH_D-1:0] i_s_tdata,
    input  logic                      i_m_vsync,
    input  logic                      i_m_hsync,
    input  logic                      i_m_reuse,
    input  logic                      i_m_valid,
    input  logic signed [WIDTH_D-1:0] i_m_tdata,
    output logic                      o_vsync,
    output logic                      o_hsync,
    output logic                      o_reuse,
    output logic                      o_valid,
    output logic signed [WIDTH_O-1:0] o_tdata,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_overflow,
    output logic                      o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = WIDTH_D + 1;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH_O+1){1'b0}}, {(WIDTH_O-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH_O+1){1'b1}}, {(WIDTH_O-1){1'b0}}};

    logic [WIDTH_D-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        level;

    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      rd_adv;
    logic                      push;
    logic                      overflow_ev;
    logic                      underflow_ev;
    logic signed [WIDTH_D-1:0] head;

    logic                      s1_valid;
    logic signed [SW-1:0]      s1_sum;
    logic signed [WIDTH_O-1:0] sat_val;

    logic [1:0] vsync_d;
    logic [1:0] hsync_d;
    logic [1:0] reuse_d;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == (AW+1)'(DEPTH));

    // A push into an empty FIFO alongside a main word advances both pointers:
    // the word is written but the main word still sees an empty head (underflow).
    assign rd_adv       = i_m_valid && !i_m_vsync && (!fifo_empty || i_s_valid);
    assign push         = i_s_valid && !i_m_vsync && (!fifo_full || rd_adv);
    assign overflow_ev  = i_s_valid && !i_m_vsync && fifo_full && !rd_adv;
    assign underflow_ev = i_m_valid && !i_m_vsync && fifo_empty;
    assign head         = fifo_empty ? '0 : $signed(mem[rd_ptr]);

    always_ff @(posedge i_sclk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= i_s_tdata;
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst || i_m_vsync) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !rd_adv) begin
                level <= level + (AW+1)'(1);
            end else if (rd_adv && !push) begin
                level <= level - (AW+1)'(1);
            end
            if (overflow_ev) begin
                o_overflow <= 1'b1;
            end
            if (underflow_ev) begin
                o_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst || i_m_vsync) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= i_m_valid;
            if (i_m_valid) begin
                s1_sum <= {i_m_tdata[WIDTH_D-1], i_m_tdata} + {head[WIDTH_D-1], head};
            end else begin
                s1_sum <= '0;
            end
        end
    end

    always_comb begin
        sat_val = s1_sum[WIDTH_O-1:0];
        if (s1_sum > SAT_MAX) begin
            sat_val = SAT_MAX[WIDTH_O-1:0];
        end else if (s1_sum < SAT_MIN) begin
            sat_val = SAT_MIN[WIDTH_O-1:0];
        end
`ifdef RESADD_RELU_EN
        if (sat_val[WIDTH_O-1]) begin
            sat_val = '0;
        end
`endif
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst || i_m_vsync) begin
            o_valid <= 1'b0;
            o_tdata <= '0;
        end else begin
            o_valid <= s1_valid;
            o_tdata <= s1_valid ? sat_val : '0;
        end
    end

    // Strobe delay line ignores vsync so the frame-start pulse still emerges.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            vsync_d <= '0;
            hsync_d <= '0;
            reuse_d <= '0;
        end else begin
            vsync_d <= {vsync_d[0], i_m_vsync};
            hsync_d <= {hsync_d[0], i_m_hsync};
            reuse_d <= {reuse_d[0], i_m_reuse};
        end
    end

    assign o_vsync = vsync_d[1];
    assign o_hsync = hsync_d[1];
    assign o_reuse = reuse_d[1];
    assign o_level = level;

endmodule
